// File: rtl/div_share_sched.sv
// rtl/div_share_sched.sv - one half-period divider time-shared among three requesters
// Define DIV_SHARE_SCHED_FIXED_PRIO_EN for fixed priority (req[0] highest); default is round-robin.
module div_share_sched #(
   parameter int W    = 8,
   parameter int HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   req,
   input  logic [W-1:0] half0,
   input  logic [W-1:0] half1,
   input  logic [W-1:0] half2,
   output logic [2:0]   grant,
   output logic         busy,
   output logic [W-1:0] count_out,
   output logic         f_out,
   output logic         done,
   output logic         abort
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

   localparam logic [7:0] TOG_LAST = 8'(HOLD - 1);

   state_t         state_q, state_d;
   logic [2:0]     grant_q, grant_d;
   logic           busy_q, busy_d;
   logic [W-1:0]   count_q, count_d;
   logic           f_q, f_d;
   logic           done_q, done_d;
   logic           abort_q, abort_d;
   logic [W-1:0]   half_sel_q, half_sel_d;
   logic [7:0]     tog_q, tog_d;
   logic           go_end;
   logic [1:0]     win_idx;
   logic [W-1:0]   win_half;
`ifndef DIV_SHARE_SCHED_FIXED_PRIO_EN
   logic [1:0]     last_q, last_d;
   logic [1:0]     c0, c1, c2;
`endif

   always_comb begin
`ifdef DIV_SHARE_SCHED_FIXED_PRIO_EN
      if (req[0])      win_idx = 2'd0;
      else if (req[1]) win_idx = 2'd1;
      else             win_idx = 2'd2;
`else
      // Candidates in search order, starting just after the last winner.
      c0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      win_idx = c2;
      if (req[c1]) win_idx = c1;
      if (req[c0]) win_idx = c0;
`endif
      case (win_idx)
         2'd0:    win_half = half0;
         2'd1:    win_half = half1;
         default: win_half = half2;
      endcase
      if (win_half == '0) win_half = W'(1);
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      count_d    = count_q;
      f_d        = f_q;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      half_sel_d = half_sel_q;
      tog_d      = tog_q;
      go_end     = 1'b0;
`ifndef DIV_SHARE_SCHED_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req != 3'b000) begin
               grant_d    = 3'b001 << win_idx;
               half_sel_d = win_half;
               count_d    = win_half;
               f_d        = 1'b0;
               tog_d      = 8'd0;
               busy_d     = 1'b1;
               state_d    = S_RUN;
`ifndef DIV_SHARE_SCHED_FIXED_PRIO_EN
               last_d     = win_idx;
`endif
            end
         end
         S_RUN: begin
            // A request drop outranks a toggle on the same edge.
            if ((req & grant_q) == 3'b000) begin
               go_end  = 1'b1;
               abort_d = 1'b1;
            end else if (count_q == W'(1)) begin
               count_d = half_sel_q;
               f_d     = ~f_q;
               tog_d   = tog_q + 8'd1;
               if (tog_q == TOG_LAST) begin
                  go_end = 1'b1;
                  done_d = 1'b1;
               end
            end else begin
               count_d = count_q - W'(1);
            end
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (go_end) begin
         state_d = S_END;
         grant_d = 3'b000;
         busy_d  = 1'b0;
         count_d = '0;
         f_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= 3'b000;
         busy_q     <= 1'b0;
         count_q    <= '0;
         f_q        <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         half_sel_q <= '0;
         tog_q      <= 8'd0;
`ifndef DIV_SHARE_SCHED_FIXED_PRIO_EN
         last_q     <= 2'd2;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
         f_q        <= f_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
         half_sel_q <= half_sel_d;
         tog_q      <= tog_d;
`ifndef DIV_SHARE_SCHED_FIXED_PRIO_EN
         last_q     <= last_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign busy      = busy_q;
   assign count_out = count_q;
   assign f_out     = f_q;
   assign done      = done_q;
   assign abort     = abort_q;

endmodule
